// File: rtl/dmem_pkg.sv
// Shared address map, STATUS bit layout and address decode for the data-memory responder.
package dmem_pkg;

  localparam logic [31:0] RamBase      = 32'h0000_0000;
  localparam logic [31:0] MmioBase     = 32'h0000_1000;
  localparam logic [31:0] LedOff       = 32'h0000_0000;
  localparam logic [31:0] TcountOff    = 32'h0000_0004;
  localparam logic [31:0] TcmpOff      = 32'h0000_0008;
  localparam logic [31:0] StatusOff    = 32'h0000_000C;

  localparam int unsigned StatusMatchBit    = 0;
  localparam int unsigned StatusMisalignBit = 1;
  localparam int unsigned StatusUnmappedBit = 2;
  localparam int unsigned StatusWidth       = 3;

  localparam logic [31:0] TcmpResetVal = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    RegNone,
    RegRam,
    RegLed,
    RegTcount,
    RegTcmp,
    RegStatus
  } region_e;

  // Misaligned addresses decode as RegNone so they can never hit a target.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned ram_bytes);
    region_e region;
    region = RegNone;
    if (addr[1:0] != 2'b00) begin
      region = RegNone;
    end else if ((addr - RamBase) < ram_bytes) begin
      region = RegRam;
    end else if (addr == MmioBase + LedOff) begin
      region = RegLed;
    end else if (addr == MmioBase + TcountOff) begin
      region = RegTcount;
    end else if (addr == MmioBase + TcmpOff) begin
      region = RegTcmp;
    end else if (addr == MmioBase + StatusOff) begin
      region = RegStatus;
    end
    return region;
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running 32-bit timer with a software-loadable count and compare register.
module dmem_timer
  import dmem_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        tcount_we_i,
  input  logic        tcmp_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] tcount_o,
  output logic [31:0] tcmp_o,
  output logic        match_o
);

  logic [31:0] tcount_q, tcount_d;
  logic [31:0] tcmp_q, tcmp_d;

  // A software load replaces that cycle's increment.
  always_comb begin
    tcount_d = tcount_we_i ? wdata_i : tcount_q + 32'd1;
    tcmp_d   = tcmp_we_i ? wdata_i : tcmp_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tcount_q <= '0;
      tcmp_q   <= TcmpResetVal;
    end else begin
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
    end
  end

  assign tcount_o = tcount_q;
  assign tcmp_o   = tcmp_q;
  assign match_o  = (tcount_q == tcmp_q);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus LED, timer and sticky STATUS registers.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic [7:0]  led,
  output logic        timer_irq
);

  localparam int unsigned RamAw    = $clog2(RAM_WORDS);
  localparam int unsigned RamBytes = 4 * RAM_WORDS;

  region_e                region;
  logic                   aligned;
  logic [RamAw-1:0]       ram_idx;
  logic [31:0]            ram_q [RAM_WORDS];
  logic [7:0]             led_q, led_d;
  logic [StatusWidth-1:0] status_q, status_d, status_set, status_clr;
  logic                   ram_we, led_we, tcount_we, tcmp_we, status_we;
  logic [31:0]            tcount, tcmp;
  logic                   match;

  assign aligned = (Mem_WrAddr[1:0] == 2'b00);
  assign region  = decode_region(Mem_WrAddr, RamBytes);
  assign ram_idx = Mem_WrAddr[RamAw+1:2];

  always_comb begin
    ram_we    = 1'b0;
    led_we    = 1'b0;
    tcount_we = 1'b0;
    tcmp_we   = 1'b0;
    status_we = 1'b0;
    if (MemWrite) begin
      unique case (region)
        RegRam:    ram_we    = ~reset;
        RegLed:    led_we    = 1'b1;
        RegTcount: tcount_we = 1'b1;
        RegTcmp:   tcmp_we   = 1'b1;
        RegStatus: status_we = 1'b1;
        default:   ;
      endcase
    end
  end

  dmem_timer u_timer (
    .clk_i       (clk),
    .reset_i     (reset),
    .tcount_we_i (tcount_we),
    .tcmp_we_i   (tcmp_we),
    .wdata_i     (Mem_WrData),
    .tcount_o    (tcount),
    .tcmp_o      (tcmp),
    .match_o     (match)
  );

  // Sets are ORed in after clears so a same-cycle set always wins.
  always_comb begin
    status_set                    = '0;
    status_set[StatusMatchBit]    = match;
    status_set[StatusMisalignBit] = MemWrite & ~aligned;
    status_set[StatusUnmappedBit] = MemWrite & aligned & (region == RegNone);
    status_clr = status_we ? Mem_WrData[StatusWidth-1:0] : '0;
    status_d   = (status_q & ~status_clr) | status_set;
    led_d      = led_we ? Mem_WrData[7:0] : led_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q    <= '0;
      status_q <= '0;
    end else begin
      led_q    <= led_d;
      status_q <= status_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= Mem_WrData;
    end
  end

  always_comb begin
    ReadData = '0;
    unique case (region)
      RegRam:    ReadData = ram_q[ram_idx];
      RegLed:    ReadData = {24'h0, led_q};
      RegTcount: ReadData = tcount;
      RegTcmp:   ReadData = tcmp;
      RegStatus: ReadData = {{(32 - StatusWidth){1'b0}}, status_q};
      default:   ;
    endcase
  end

  assign led       = led_q;
  assign timer_irq = status_q[StatusMatchBit];

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, directed corner sequences, random traffic.
module tb_dmem_responder;

  localparam int RW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic [7:0]  led;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd_sample;

  // Reference model state
  logic [31:0] m_ram [RW];
  logic [7:0]  m_led;
  logic [31:0] m_tcount;
  logic [31:0] m_tcmp;
  logic [2:0]  m_status;

  always #5 clk = ~clk;

  dmem_responder #(.RAM_WORDS(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .ReadData   (ReadData),
    .led        (led),
    .timer_irq  (timer_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 32'h0;
    if (a < 4 * RW) return m_ram[a / 4];
    case (a)
      32'h1000: return {24'h0, m_led};
      32'h1004: return m_tcount;
      32'h1008: return m_tcmp;
      32'h100C: return {29'h0, m_status};
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
    logic [2:0]  set;
    logic [2:0]  clr;
    logic [31:0] nxt;
    if (rst) begin
      m_led    = 8'h0;
      m_tcount = 32'h0;
      m_tcmp   = 32'hFFFF_FFFF;
      m_status = 3'h0;
    end else begin
      set    = 3'h0;
      clr    = 3'h0;
      set[0] = (m_tcount == m_tcmp);
      nxt    = m_tcount + 32'd1;
      if (we) begin
        if (a[1:0] != 2'b00) set[1] = 1'b1;
        else if (a < 4 * RW) m_ram[a / 4] = d;
        else begin
          case (a)
            32'h1000: m_led = d[7:0];
            32'h1004: nxt = d;
            32'h1008: m_tcmp = d;
            32'h100C: clr = d[2:0];
            default:  set[2] = 1'b1;
          endcase
        end
      end
      m_tcount = nxt;
      m_status = (m_status & ~clr) | set;
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, clock edge, advance the model.
  task automatic cycle(input logic rst, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input bit chk);
    reset      = rst;
    MemWrite   = we;
    Mem_WrAddr = a;
    Mem_WrData = d;
    #2;
    rd_sample = ReadData;
    if (chk) begin
      check($sformatf("model rd[%08h]", a), ReadData, model_read(a));
      check("model led", {24'h0, led}, {24'h0, m_led});
      check("model irq", {31'h0, timer_irq}, {31'h0, m_status[0]});
    end
    @(posedge clk);
    model_step(rst, we, a, d);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset      = 1'b1;
    MemWrite   = 1'b0;
    Mem_WrAddr = 32'h0;
    Mem_WrData = 32'h0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h1000, 32'hFF, 1'b0);

    // Reset state and first count after release
    check("rst led", {24'h0, led}, 32'h0);
    check("rst irq", {31'h0, timer_irq}, 32'h0);
    cycle(1'b0, 1'b0, 32'h1004, 32'h0, 1'b1);
    check("rst tcount", rd_sample, 32'h0);
    cycle(1'b0, 1'b0, 32'h1004, 32'h0, 1'b1);
    check("tcount after release", rd_sample, 32'h1);
    cycle(1'b0, 1'b0, 32'h1008, 32'h0, 1'b1);
    check("rst tcmp", rd_sample, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'h100C, 32'h0, 1'b1);
    check("rst status", rd_sample, 32'h0);

    // Give every RAM word a known value
    for (int i = 0; i < RW; i++) begin
      cycle(1'b0, 1'b1, 32'(i * 4), 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000, 1'b0);
    end

    vecs.push_back('{1'b1, 32'h0000_0014, 32'h1111_1111, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,         1'b1, 32'h1111_1111});
    vecs.push_back('{1'b1, 32'h0000_0012, 32'h0000_1234, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h2});
    vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_1000, 32'h0000_01A5, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'hA5});
    vecs.push_back('{1'b1, 32'h0000_2000, 32'h0000_0055, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h6});
    vecs.push_back('{1'b0, 32'h0000_2000, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_1003, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h6});
    vecs.push_back('{1'b1, 32'h0000_100C, 32'h0000_0006, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'hCAFE_F00D});
    vecs.push_back('{1'b0, 32'h0000_1010, 32'h0,         1'b1, 32'h0});

    foreach (vecs[i]) begin
      cycle(1'b0, vecs[i].we, vecs[i].addr, vecs[i].data, 1'b1);
      if (vecs[i].chk) check($sformatf("vec %0d", i), rd_sample, vecs[i].exp);
    end

    // Timer match six edges after the TCOUNT write, then W1C
    cycle(1'b0, 1'b1, 32'h1008, 32'd5, 1'b1);
    cycle(1'b0, 1'b1, 32'h1004, 32'd0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 1'b0, 32'h100C, 32'h0, 1'b1);
      if (k == 5) check("irq before match", {31'h0, timer_irq}, 32'h0);
    end
    check("irq at match", {31'h0, timer_irq}, 32'h1);
    cycle(1'b0, 1'b0, 32'h100C, 32'h0, 1'b1);
    check("status match", rd_sample, 32'h1);
    cycle(1'b0, 1'b1, 32'h100C, 32'h1, 1'b1);
    check("irq cleared", {31'h0, timer_irq}, 32'h0);
    cycle(1'b0, 1'b0, 32'h100C, 32'h0, 1'b1);
    check("status cleared", rd_sample, 32'h0);

    // Wrap from all-ones with TCMP=0
    cycle(1'b0, 1'b1, 32'h1008, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h1004, 32'hFFFF_FFFF, 1'b1);
    cycle(1'b0, 1'b0, 32'h1004, 32'h0, 1'b1);
    check("tcount max", rd_sample, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'h1004, 32'h0, 1'b1);
    check("tcount wrapped", rd_sample, 32'h0);
    cycle(1'b0, 1'b0, 32'h100C, 32'h0, 1'b1);
    check("status wrap match", rd_sample, 32'h1);
    check("irq wrap match", {31'h0, timer_irq}, 32'h1);

    // Set and clear of STATUS[0] in the same cycle
    cycle(1'b0, 1'b1, 32'h1004, 32'd100, 1'b1);
    cycle(1'b0, 1'b1, 32'h1008, 32'd10, 1'b1);
    cycle(1'b0, 1'b1, 32'h100C, 32'h7, 1'b1);
    check("irq before race", {31'h0, timer_irq}, 32'h0);
    cycle(1'b0, 1'b1, 32'h1004, 32'd8, 1'b1);
    cycle(1'b0, 1'b0, 32'h1004, 32'h0, 1'b1);
    check("race tcount 8", rd_sample, 32'd8);
    cycle(1'b0, 1'b0, 32'h1004, 32'h0, 1'b1);
    check("race tcount 9", rd_sample, 32'd9);
    cycle(1'b0, 1'b1, 32'h100C, 32'h1, 1'b1);
    check("set wins irq", {31'h0, timer_irq}, 32'h1);
    cycle(1'b0, 1'b0, 32'h100C, 32'h0, 1'b1);
    check("set wins status", rd_sample, 32'h1);

    // Reset mid-operation with a concurrent LED write
    cycle(1'b0, 1'b1, 32'h1000, 32'hA5, 1'b1);
    cycle(1'b0, 1'b1, 32'h1008, 32'd50, 1'b1);
    cycle(1'b0, 1'b1, 32'h1004, 32'd50, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0012, 32'h1234, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_3000, 32'h1, 1'b1);
    cycle(1'b0, 1'b0, 32'h100C, 32'h0, 1'b1);
    check("pre-reset status", rd_sample, 32'h7);
    check("pre-reset led", {24'h0, led}, 32'hA5);
    cycle(1'b1, 1'b1, 32'h1000, 32'h3C, 1'b1);
    check("post-reset led", {24'h0, led}, 32'h0);
    check("post-reset irq", {31'h0, timer_irq}, 32'h0);
    cycle(1'b0, 1'b0, 32'h100C, 32'h0, 1'b1);
    check("post-reset status", rd_sample, 32'h0);
    cycle(1'b0, 1'b0, 32'h1008, 32'h0, 1'b1);
    check("post-reset tcmp", rd_sample, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    check("ram kept", rd_sample, 32'hDEAD_BEEF);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic        we;
      logic        rst;
      int          sel;
      sel = $urandom_range(0, 9);
      d   = $urandom;
      case (sel)
        0, 1, 2, 3: begin
          a = 32'($urandom_range(0, RW - 1)) << 2;
          if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        end
        4: a = 32'h1000;
        5: a = 32'h1004;
        6: begin
          a = 32'h1008;
          d = m_tcount + 32'($urandom_range(0, 4));
        end
        7: begin
          a = 32'h100C;
          d = 32'($urandom_range(0, 7));
        end
        8: a = 32'($urandom_range(32'h400, 32'hFFF));
        default: a = $urandom;
      endcase
      we  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 80) == 0);
      cycle(rst, we, a, d, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
